// File: rtl/io_arb_pkg.sv
// Shared types and defaults for the I/O port arbiter.
//   arb_state_t : arbiter FSM states
//   mst_idx_t   : master index (0 = m0 / CPU, 1 = m1 / auxiliary)
package io_arb_pkg;

  localparam int ADDR_W_DEF = 5;   // 3-bit device select + 2-bit register select
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef logic mst_idx_t;

endpackage

// File: rtl/io_arb_rr.sv
// Two-way round-robin picker with last-grant register.
// Ports:
//   clk, rst_n          : clock, async active-low reset (last grant -> m1)
//   req0, req1          : requests from m0 / m1
//   upd                 : commit the current pick into the last-grant register
//   force_en, force_idx : restrict the pick to one master (bus lock)
//   gnt_vld, gnt_idx    : combinational pick result
module io_arb_rr
  import io_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     req0,
  input  logic     req1,
  input  logic     upd,
  input  logic     force_en,
  input  mst_idx_t force_idx,
  output logic     gnt_vld,
  output mst_idx_t gnt_idx
);

  mst_idx_t last;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last;
    if (force_en) begin
      // Locked owner: the other master is not eligible even if requesting.
      gnt_idx = force_idx;
      gnt_vld = force_idx ? req1 : req0;
    end else if (req0 && req1) begin
      gnt_vld = 1'b1;
      gnt_idx = ~last;
    end else if (req0 || req1) begin
      gnt_vld = 1'b1;
      gnt_idx = req1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              last <= 1'b1;  // m0 wins the first tie
    else if (upd && gnt_vld) last <= gnt_idx;
  end

endmodule

// File: rtl/io_port_arbiter.sv
// Arbitrates two bus masters (m0 = CPU, m1 = auxiliary) onto one I/O port.
// Each transaction: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (ack pulse).
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   mN_req/we/dir/wdata/lock         : master request side
//   mN_ack, mN_rdata                 : completion pulse, captured read data
//   dev_dir/dev_wdata/dev_we         : registered drive to I/O decode logic
//   dev_rdata                        : data back from I/O decode logic
// Build option: define IO_ARB_LOCK_EN to honour mN_lock (owner keeps the
// bus across DONE while its lock is high); otherwise lock is ignored.
module io_port_arbiter
  import io_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_dir,
  input  logic [ADDR_W-1:0] m1_dir,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m0_lock,
  input  logic              m1_lock,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] dev_dir,
  output logic [DATA_W-1:0] dev_wdata,
  output logic              dev_we,
  input  logic [DATA_W-1:0] dev_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  arb_state_t          state;
  logic [3:0]          cnt;
  mst_idx_t            owner;
  logic                cur_we;
  logic                gnt_vld;
  mst_idx_t            gnt_idx;
  logic                force_en;
  mst_idx_t            force_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_dir;
  logic [DATA_W-1:0]   sel_wdata;

`ifdef IO_ARB_LOCK_EN
  logic     lock_hold;
  mst_idx_t lock_owner;
  // Lock stays in force only while the owner keeps its lock line high.
  assign force_en  = lock_hold && (lock_owner ? m1_lock : m0_lock);
  assign force_idx = lock_owner;
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
  assign force_en    = 1'b0;
  assign force_idx   = 1'b0;
`endif

  io_arb_rr u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (m0_req),
    .req1      (m1_req),
    .upd       (state == IDLE),
    .force_en  (force_en),
    .force_idx (force_idx),
    .gnt_vld   (gnt_vld),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_we    = gnt_idx ? m1_we    : m0_we;
    sel_dir   = gnt_idx ? m1_dir   : m0_dir;
    sel_wdata = gnt_idx ? m1_wdata : m0_wdata;
  end

  // dev_dir/dev_wdata double as the latched request for the whole ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      cur_we    <= 1'b0;
      dev_dir   <= '0;
      dev_wdata <= '0;
      dev_we    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
`ifdef IO_ARB_LOCK_EN
      lock_hold  <= 1'b0;
      lock_owner <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            owner     <= gnt_idx;
            cur_we    <= sel_we;
            dev_dir   <= sel_dir;
            dev_wdata <= sel_wdata;
            // With no wait cycles the first ACCESS cycle is also the last.
            dev_we    <= sel_we && (WAIT_INIT == 4'd0);
            cnt       <= WAIT_INIT;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (owner) begin
              m1_rdata <= dev_rdata;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= dev_rdata;
              m0_ack   <= 1'b1;
            end
            dev_dir   <= '0;
            dev_wdata <= '0;
            dev_we    <= 1'b0;
            state     <= DONE;
          end else begin
            cnt    <= cnt - 4'd1;
            dev_we <= cur_we && (cnt == 4'd1);
          end
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
`ifdef IO_ARB_LOCK_EN
          lock_hold  <= owner ? m1_lock : m0_lock;
          lock_owner <= owner;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
